axis_fifo_arbiter: RTL and testbench

//  Round-robin arbiter sharing one AXI-Stream FIFO write port between NUM_INPUTS producers.

---
 rtl/axis_fifo_arbiter_if.sv | 35 +++
 rtl/axis_fifo_arbiter.sv | 138 +++++++++++++
 tb/tb_axis_fifo_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_fifo_arbiter_if.sv
// Producer-side and FIFO-side AXI-Stream signals of the burst arbiter; slave modport is the arbiter, master the environment.
// Optional tlast wires are present when AXIS_FIFO_ARBITER_TLAST_EN is defined.
interface axis_fifo_arbiter_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int TDATA_WIDTH = 32
);
  logic [NUM_INPUTS*TDATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_INPUTS-1:0]             s_axis_tvalid;
  logic [NUM_INPUTS-1:0]             s_axis_tready;
  logic [TDATA_WIDTH-1:0]            m_axis_tdata;
  logic                              m_axis_tvalid;
  logic                              m_axis_tready;
`ifdef AXIS_FIFO_ARBITER_TLAST_EN
  logic [NUM_INPUTS-1:0]             s_axis_tlast;
  logic                              m_axis_tlast;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
`else
  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
`endif
endinterface

// File: rtl/axis_fifo_arbiter.sv
// Round-robin burst arbiter onto one FIFO write port; grants only when the FIFO has room for BURST_LEN beats.
// First beat 1 cycle after grant, 2-cycle gap between bursts, m_axis_tready stalls the burst; tlast option: AXIS_FIFO_ARBITER_TLAST_EN.
module axis_fifo_arbiter #(
  parameter int NUM_INPUTS  = 4,
  parameter int TDATA_WIDTH = 32,
  parameter int BURST_LEN   = 16,
  parameter int FIFO_DEPTH  = 512
) (
  input  logic                  aclk,
  input  logic                  areset,
  axis_fifo_arbiter_if.slave    bus,
  input  logic [31:0]           fifo_write_count,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  busy
);
  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, BURST, SETTLE} state_t;

  state_t                state_q, state_d;
  logic [NUM_INPUTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  logic                  space_ok;
  logic                  found;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W:0]        cand;
  logic                  beat;
  logic                  burst_end;
  logic [IDX_W-1:0]      sel_next;

  // Widened to 33 bits so a huge write count cannot wrap into "room available".
  assign space_ok = ({1'b0, fifo_write_count} + 33'(BURST_LEN)) <= 33'(FIFO_DEPTH);

  always_comb begin
    found   = 1'b0;
    win_idx = rr_q;
    cand    = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_INPUTS)) begin
        cand = cand - (IDX_W+1)'(NUM_INPUTS);
      end
      if (!found && bus.s_axis_tvalid[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    bus.m_axis_tdata  = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.s_axis_tready = '0;
`ifdef AXIS_FIFO_ARBITER_TLAST_EN
    bus.m_axis_tlast  = 1'b0;
`endif
    if (state_q == BURST) begin
      bus.m_axis_tdata         = bus.s_axis_tdata[int'(sel_q)*TDATA_WIDTH +: TDATA_WIDTH];
      bus.m_axis_tvalid        = bus.s_axis_tvalid[sel_q];
      bus.s_axis_tready[sel_q] = bus.m_axis_tready;
`ifdef AXIS_FIFO_ARBITER_TLAST_EN
      bus.m_axis_tlast         = bus.s_axis_tlast[sel_q];
`endif
    end
  end

  assign beat     = (state_q == BURST) && bus.s_axis_tvalid[sel_q] && bus.m_axis_tready;
  assign sel_next = (sel_q == IDX_W'(NUM_INPUTS-1)) ? '0 : sel_q + IDX_W'(1);

`ifdef AXIS_FIFO_ARBITER_TLAST_EN
  assign burst_end = beat && ((cnt_q == CNT_W'(BURST_LEN-1)) || bus.s_axis_tlast[sel_q]);
`else
  // A non-zero count means at least one beat has already gone out in this burst.
  assign burst_end = (beat && (cnt_q == CNT_W'(BURST_LEN-1)))
                   || (!bus.s_axis_tvalid[sel_q] && (cnt_q != '0));
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (found && space_ok) begin
          state_d          = BURST;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          sel_d            = win_idx;
          cnt_d            = '0;
          busy_d           = 1'b1;
        end
      end
      BURST: begin
        if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (burst_end) begin
          state_d = SETTLE;
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = sel_next;
          cnt_d   = '0;
        end
      end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Bench for axis_fifo_arbiter (4 inputs, 32-bit, BURST_LEN 16, depth 512): producer models feed the inputs,
// an expected-beat queue is filled per scenario and checked against every FIFO-side handshake.
module tb_axis_fifo_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    logic [3:0]  gnt;
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [31:0] fwc;
    logic [3:0]  req;
    logic [3:0]  gnt;
  } vec_t;

  logic        aclk;
  logic        areset;
  logic [31:0] fwc;
  logic [3:0]  grant;
  logic        busy;

  axis_fifo_arbiter_if #(.NUM_INPUTS(N), .TDATA_WIDTH(W)) bus();

  axis_fifo_arbiter #(.NUM_INPUTS(N), .TDATA_WIDTH(W), .BURST_LEN(16), .FIFO_DEPTH(512)) dut (
    .aclk             (aclk),
    .areset           (areset),
    .bus              (bus),
    .fifo_write_count (fwc),
    .grant            (grant),
    .busy             (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int   total, bad, beats, cyc;
  int   en[N];
  int   rem[N];
  int   seq[N];
  logic [3:0] hs;
  exp_t exp_q[$];
  int   beat_cyc[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.s_axis_tvalid[i]          = (en[i] != 0) && (rem[i] != 0);
      bus.s_axis_tdata[i*W +: W]    = {8'(i), 24'(seq[i])};
`ifdef AXIS_FIFO_ARBITER_TLAST_EN
      bus.s_axis_tlast[i]           = (rem[i] == 1);
`endif
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic m_hs;
    hs   = bus.s_axis_tvalid & bus.s_axis_tready;
    m_hs = bus.m_axis_tvalid & bus.m_axis_tready;
    if (m_hs || hs != 0) chk("ready_route", $countones(hs), m_hs ? 1 : 0);
    if (m_hs) begin
      beats++;
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", bus.m_axis_tdata, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", {grant, bus.m_axis_tdata}, {e.gnt, e.data});
`ifdef AXIS_FIFO_ARBITER_TLAST_EN
        chk("beat_last", bus.m_axis_tlast, e.last);
`endif
      end
    end
  endtask

  // One clock: observe on the falling edge, update producers just after the rising edge.
  task automatic step();
    drive();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        seq[i]++;
        if (rem[i] > 0) rem[i]--;
      end
    end
    drive();
  endtask

  task automatic clear_prod();
    for (int i = 0; i < N; i++) begin
      en[i] = 0; rem[i] = 0; seq[i] = 0;
    end
    drive();
  endtask

  task automatic push_exp(input int i, input int s, input logic last);
    exp_t e;
    e.gnt  = 4'(1 << i);
    e.data = {8'(i), 24'(s)};
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int start;
    int k;
    start = beats;
    k = 0;
    while ((beats - start) < n && k < budget) begin
      step();
      k++;
    end
    chk({name, "_beats"}, beats - start, n);
  endtask

  task automatic wait_busy(input int budget, input string name);
    int k;
    k = 0;
    while (!busy && k < budget) begin
      step();
      k++;
    end
    chk(name, busy, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng, b0, bcnt, grants;
    logic prev_busy;

    vecs[0] = '{32'd0,          4'b0001, 4'b0001};
    vecs[1] = '{32'd496,        4'b0100, 4'b0100};
    vecs[2] = '{32'd497,        4'b0001, 4'b0000};
    vecs[3] = '{32'd512,        4'b1111, 4'b0000};
    vecs[4] = '{32'd600,        4'b1000, 4'b0000};
    vecs[5] = '{32'hFFFF_FFF8,  4'b0010, 4'b0000};
    vecs[6] = '{32'd100,        4'b1010, 4'b0010};
    vecs[7] = '{32'd0,          4'b1100, 4'b0100};
    vecs[8] = '{32'd0,          4'b0000, 4'b0000};

    total = 0; bad = 0; beats = 0; cyc = 0;
    fwc = 0;
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
`ifdef AXIS_FIFO_ARBITER_TLAST_EN
    bus.s_axis_tlast  = '0;
`endif
    clear_prod();

    // Reset held with every input requesting.
    for (int i = 0; i < N; i++) begin en[i] = 1; rem[i] = -1; end
    areset = 1'b1;
    repeat (3) step();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_tready", bus.s_axis_tready, 4'b0000);
    chk("rst_m_tvalid", bus.m_axis_tvalid, 1'b0);
    clear_prod();
    step();
    areset = 1'b0;

    // Table: space check and priority from a freshly reset pointer; FIFO stalled so no beats move.
    for (int v = 0; v < 9; v++) begin
      bus.m_axis_tready = 1'b0;
      fwc = vecs[v].fwc;
      for (int i = 0; i < N; i++) begin en[i] = vecs[v].req[i]; rem[i] = -1; seq[i] = 0; end
      areset = 1'b1;
      step();
      areset = 1'b0;
      step();
      step();
      chk("tbl_grant", grant, vecs[v].gnt);
      chk("tbl_busy", busy, |vecs[v].gnt);
      chk("tbl_m_tvalid", bus.m_axis_tvalid, |vecs[v].gnt);
      chk("tbl_s_tready", bus.s_axis_tready, 4'b0000);
    end
    clear_prod();
    areset = 1'b1;
    step();
    areset = 1'b0;
    fwc = 0;
    bus.m_axis_tready = 1'b1;

    // Round robin with all inputs saturated: 0,1,2,3,0, 16 beats each, 2 idle cycles between bursts.
    b0 = beat_cyc.size();
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 16; k++) push_exp(b % 4, (b / 4) * 16 + k, 1'b0);
    for (int i = 0; i < N; i++) begin en[i] = 1; rem[i] = -1; end
    wait_beats(80, 200, "rr");
    clear_prod();
    repeat (3) step();
    chk("rr_drain", exp_q.size(), 0);
    if (beat_cyc.size() >= b0 + 80) begin
      for (int k = 1; k < 80; k++)
        chk("rr_spacing", beat_cyc[b0+k] - beat_cyc[b0+k-1], (k % 16 == 0) ? 3 : 1);
    end

    // Space check: 497 blocks, 496 grants on the very next edge.
    fwc = 497;
    en[0] = 1; rem[0] = -1;
    ng = 0;
    repeat (5) begin
      step();
      if (grant != 0 || bus.s_axis_tready != 0 || busy) ng++;
    end
    chk("space_block", ng, 0);
    for (int k = 0; k < 16; k++) push_exp(0, k, 1'b0);
    fwc = 496;
    step();
    chk("space_grant", grant, 4'b0001);
    fwc = 512;
    wait_beats(16, 40, "space");
    repeat (3) step();
    chk("space_hold", {busy, grant}, 5'b0);
    clear_prod();
    fwc = 0;

    // Short bursts: pointer sits at 1, so 2 then 3 then 0 are served.
    b0 = beat_cyc.size();
    for (int k = 0; k < 5; k++) push_exp(2, k, k == 4);
    for (int k = 0; k < 4; k++) push_exp(3, k, k == 3);
    for (int k = 0; k < 2; k++) push_exp(0, k, k == 1);
    en[0] = 1; rem[0] = 2;
    en[2] = 1; rem[2] = 5;
    en[3] = 1; rem[3] = 4;
    wait_beats(11, 80, "short");
    repeat (3) step();
    chk("short_idle", {busy, grant}, 5'b0);
    chk("short_drain", exp_q.size(), 0);
    if (beat_cyc.size() >= b0 + 6) begin
`ifdef AXIS_FIFO_ARBITER_TLAST_EN
      chk("short_gap", beat_cyc[b0+5] - beat_cyc[b0+4], 3);
`else
      chk("short_gap", beat_cyc[b0+5] - beat_cyc[b0+4], 4);
`endif
    end
    clear_prod();

    // Granted input goes quiet before its first beat: grant must be held.
    bus.m_axis_tready = 1'b0;
    en[0] = 1; rem[0] = 3;
    wait_busy(10, "idle_first_busy");
    chk("idle_first_grant", grant, 4'b0001);
    en[0] = 0;
    ng = 0;
    repeat (3) begin
      step();
      if (!busy || grant != 4'b0001) ng++;
    end
    chk("idle_first_hold", ng, 0);
    for (int k = 0; k < 3; k++) push_exp(0, k, k == 2);
    en[0] = 1;
    bus.m_axis_tready = 1'b1;
    wait_beats(3, 20, "idle_first");
    repeat (3) step();
    chk("idle_first_end", busy, 1'b0);
    clear_prod();

    // Backpressure: tready low on the first burst cycle then alternating; then a re-grant to the lone requester.
    for (int k = 0; k < 32; k++) push_exp(1, k, k == 31);
    en[1] = 1; rem[1] = 32;
    b0 = beats;
    bcnt = 0;
    for (int n = 0; n < 80; n++) begin
      step();
      if (busy) begin
        bcnt++;
        if (bcnt == 1) fwc = 512;
        bus.m_axis_tready = (bcnt % 2 == 0);
      end else if (bcnt > 0) begin
        break;
      end
    end
    chk("bp_cycles", bcnt, 32);
    chk("bp_beats", beats - b0, 16);
    fwc = 0;
    bus.m_axis_tready = 1'b1;
    wait_beats(16, 40, "regrant");
    repeat (3) step();
    chk("regrant_drain", exp_q.size(), 0);
    clear_prod();

    // Reset in the middle of a burst: truncated, then resumes from the next undelivered beat.
    bus.m_axis_tready = 1'b0;
    for (int k = 0; k < 20; k++) push_exp(3, k, k == 19);
    en[3] = 1; rem[3] = 20;
    wait_busy(10, "mid_rst_busy");
    bus.m_axis_tready = 1'b1;
    b0 = beats;
    repeat (4) step();
    chk("mid_rst_pre", beats - b0, 4);
    bus.m_axis_tready = 1'b0;
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("mid_rst_state", {busy, grant, bus.m_axis_tvalid}, 6'b0);
    bus.m_axis_tready = 1'b1;
    wait_beats(16, 40, "mid_rst");
    repeat (3) step();
    chk("mid_rst_end", busy, 1'b0);
    clear_prod();

`ifdef AXIS_FIFO_ARBITER_TLAST_EN
    // Packet with tvalid gaps: one grant only, ending on the tlast beat.
    for (int k = 0; k < 3; k++) push_exp(0, k, k == 2);
    rem[0] = 3;
    b0 = beats;
    grants = 0;
    prev_busy = 1'b0;
    for (int k = 0; k < 30; k++) begin
      en[0] = k % 2;
      step();
      if (busy && !prev_busy) grants++;
      prev_busy = busy;
    end
    chk("tlast_beats", beats - b0, 3);
    chk("tlast_grants", grants, 1);
    chk("tlast_end", busy, 1'b0);
    clear_prod();
`else
    grants = 0;
    prev_busy = 1'b0;
`endif

    step();
    chk("final_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
